// File: rtl/lcd_byte_writer.sv
// HD44780 4-bit byte writer: one byte per valid/ready handshake, sent high nibble first. oReady returns 2S+2P+2H+G+B+1 cycles after accept.
// oReady stays low while a byte is in flight. Define LCD_CLEAR_DELAY_EN to stretch the post-byte gap after clear/home commands.
module lcd_byte_writer #(
  parameter int SETUP_CYCLES      = 2,
  parameter int PULSE_CYCLES      = 12,
  parameter int HOLD_CYCLES       = 1,
  parameter int NIBBLE_GAP_CYCLES = 50,
  parameter int BYTE_GAP_CYCLES   = 2000,
  parameter int CLEAR_GAP_CYCLES  = 82000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iValid,
  output logic       oReady,
  input  logic       iRegisterSelect,
  input  logic [7:0] iData,
  output logic       oBusy,
  output logic       oLCD_Enabled,
  output logic       oLCD_RegisterSelect,
  output logic       oLCD_ReadWrite,
  output logic       oLCD_StrataFlashControl,
  output logic [3:0] oLCD_Data
);

  localparam int CW = 17;

  // Reload value is N-1 so a state lasts N cycles; N=0 behaves like 1.
  function automatic logic [CW-1:0] load_of(input int n);
    return (n <= 1) ? '0 : CW'(n - 1);
  endfunction

  localparam logic [CW-1:0] SETUP_LD = load_of(SETUP_CYCLES);
  localparam logic [CW-1:0] PULSE_LD = load_of(PULSE_CYCLES);
  localparam logic [CW-1:0] HOLD_LD  = load_of(HOLD_CYCLES);
  localparam logic [CW-1:0] NGAP_LD  = load_of(NIBBLE_GAP_CYCLES);
  localparam logic [CW-1:0] BGAP_LD  = load_of(BYTE_GAP_CYCLES);
  localparam logic [CW-1:0] CGAP_LD  = load_of(CLEAR_GAP_CYCLES);

  typedef enum logic [3:0] {
    IDLE, HI_SETUP, HI_PULSE, HI_HOLD, NIB_GAP,
    LO_SETUP, LO_PULSE, LO_HOLD, BYTE_GAP
  } state_t;

  state_t          state_q, state_n;
  logic [CW-1:0]   cnt_q, cnt_n;
  logic [7:0]      byte_q, byte_n;
  logic            rs_q, rs_n;
  logic            long_q, long_n;
  logic            accept, is_clear;
  logic            e_n, lcd_rs_n;
  logic [3:0]      data_n;

  assign oReady                  = (state_q == IDLE) && !Reset;
  assign oBusy                   = (state_q != IDLE);
  assign accept                  = iValid && oReady;
  assign oLCD_ReadWrite          = 1'b0;
  assign oLCD_StrataFlashControl = 1'b1;

`ifdef LCD_CLEAR_DELAY_EN
  assign is_clear = !iRegisterSelect && ((iData == 8'h01) || (iData == 8'h02));
`else
  assign is_clear = 1'b0;
`endif

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    byte_n  = byte_q;
    rs_n    = rs_q;
    long_n  = long_q;
    if (state_q == IDLE) begin
      if (accept) begin
        state_n = HI_SETUP;
        cnt_n   = SETUP_LD;
        byte_n  = iData;
        rs_n    = iRegisterSelect;
        long_n  = is_clear;
      end
    end else if (cnt_q != '0) begin
      cnt_n = cnt_q - CW'(1);
    end else begin
      case (state_q)
        HI_SETUP: begin state_n = HI_PULSE; cnt_n = PULSE_LD; end
        HI_PULSE: begin state_n = HI_HOLD;  cnt_n = HOLD_LD;  end
        HI_HOLD:  begin state_n = NIB_GAP;  cnt_n = NGAP_LD;  end
        NIB_GAP:  begin state_n = LO_SETUP; cnt_n = SETUP_LD; end
        LO_SETUP: begin state_n = LO_PULSE; cnt_n = PULSE_LD; end
        LO_PULSE: begin state_n = LO_HOLD;  cnt_n = HOLD_LD;  end
        LO_HOLD:  begin state_n = BYTE_GAP; cnt_n = long_q ? CGAP_LD : BGAP_LD; end
        default:  begin state_n = IDLE;     cnt_n = '0;       end
      endcase
    end
  end

  // Pin values are decoded from the next state so the pins come straight off flops.
  always_comb begin
    e_n      = (state_n == HI_PULSE) || (state_n == LO_PULSE);
    lcd_rs_n = (state_n != IDLE) ? rs_n : 1'b0;
    data_n   = 4'h0;
    if (state_n inside {HI_SETUP, HI_PULSE, HI_HOLD, NIB_GAP})
      data_n = byte_n[7:4];
    else if (state_n != IDLE)
      data_n = byte_n[3:0];
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q             <= IDLE;
      cnt_q               <= '0;
      byte_q              <= 8'h00;
      rs_q                <= 1'b0;
      long_q              <= 1'b0;
      oLCD_Enabled        <= 1'b0;
      oLCD_RegisterSelect <= 1'b0;
      oLCD_Data           <= 4'h0;
    end else begin
      state_q             <= state_n;
      cnt_q               <= cnt_n;
      byte_q              <= byte_n;
      rs_q                <= rs_n;
      long_q              <= long_n;
      oLCD_Enabled        <= e_n;
      oLCD_RegisterSelect <= lcd_rs_n;
      oLCD_Data           <= data_n;
    end
  end

endmodule

// File: tb/tb_lcd_byte_writer.sv
// Bench for lcd_byte_writer with short timing parameters; each byte is compared cycle by cycle against an expected pin trace.
module tb_lcd_byte_writer;
  localparam int S = 2, P = 3, H = 1, G = 4, B = 6, C = 20;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       iValid = 1'b0;
  logic       iRegisterSelect = 1'b0;
  logic [7:0] iData = 8'h00;
  logic       oReady, oBusy, oLCD_Enabled, oLCD_RegisterSelect;
  logic       oLCD_ReadWrite, oLCD_StrataFlashControl;
  logic [3:0] oLCD_Data;
  logic [7:0] obs;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  lcd_byte_writer #(
    .SETUP_CYCLES(S), .PULSE_CYCLES(P), .HOLD_CYCLES(H),
    .NIBBLE_GAP_CYCLES(G), .BYTE_GAP_CYCLES(B), .CLEAR_GAP_CYCLES(C)
  ) dut (
    .Clock(Clock), .Reset(Reset), .iValid(iValid), .oReady(oReady),
    .iRegisterSelect(iRegisterSelect), .iData(iData), .oBusy(oBusy),
    .oLCD_Enabled(oLCD_Enabled), .oLCD_RegisterSelect(oLCD_RegisterSelect),
    .oLCD_ReadWrite(oLCD_ReadWrite), .oLCD_StrataFlashControl(oLCD_StrataFlashControl),
    .oLCD_Data(oLCD_Data)
  );

  always #5 Clock = ~Clock;

  // Observed word: {E, RS, Data[3:0], busy, ready}
  assign obs = {oLCD_Enabled, oLCD_RegisterSelect, oLCD_Data, oBusy, oReady};

  function automatic int eff(input int n);
    return (n < 1) ? 1 : n;
  endfunction

  function automatic bit long_gap_of(input bit rs, input logic [7:0] b);
`ifdef LCD_CLEAR_DELAY_EN
    return !rs && ((b == 8'h01) || (b == 8'h02));
`else
    return 1'b0;
`endif
  endfunction

  function automatic int latency_of(input bit rs, input logic [7:0] b);
    return 2*eff(S) + 2*eff(P) + 2*eff(H) + eff(G) + (long_gap_of(rs, b) ? eff(C) : eff(B)) + 1;
  endfunction

  // Expected pin trace for the cycles following an accept edge, ending on the first ready cycle.
  function automatic void build_expect(input bit rs, input logic [7:0] b);
    logic [3:0] hi, lo;
    int gap;
    hi  = b[7:4];
    lo  = b[3:0];
    gap = long_gap_of(rs, b) ? eff(C) : eff(B);
    exp_q.delete();
    repeat (eff(S)) exp_q.push_back({1'b0, rs, hi, 2'b10});
    repeat (eff(P)) exp_q.push_back({1'b1, rs, hi, 2'b10});
    repeat (eff(H)) exp_q.push_back({1'b0, rs, hi, 2'b10});
    repeat (eff(G)) exp_q.push_back({1'b0, rs, hi, 2'b10});
    repeat (eff(S)) exp_q.push_back({1'b0, rs, lo, 2'b10});
    repeat (eff(P)) exp_q.push_back({1'b1, rs, lo, 2'b10});
    repeat (eff(H)) exp_q.push_back({1'b0, rs, lo, 2'b10});
    repeat (gap)    exp_q.push_back({1'b0, rs, lo, 2'b10});
    exp_q.push_back(8'b0000_0001);
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!oReady && n < 200) begin
      @(negedge Clock);
      n++;
    end
    if (!oReady) begin
      total++; bad++;
      $display("FAIL wait_ready: oReady=%b after %0d cycles, required 1", oReady, n);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; iValid = 1'b0;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    total++;
    if (obs !== 8'h00) begin bad++; $display("FAIL reset_hold: got=%b want=%b", obs, 8'h00); end
    total++;
    if ({oLCD_ReadWrite, oLCD_StrataFlashControl} !== 2'b01)
      begin bad++; $display("FAIL const_pins: got=%b want=01", {oLCD_ReadWrite, oLCD_StrataFlashControl}); end
    Reset = 1'b0;
    #1;
    total++;
    if (obs !== 8'h01) begin bad++; $display("FAIL reset_release: got=%b want=%b", obs, 8'h01); end
  endtask

  task automatic test_single_a5();
    int e_hi = 0, e_lo = 0, lat = 0;
    wait_ready();
    iValid = 1'b1; iRegisterSelect = 1'b1; iData = 8'hA5;
    build_expect(1'b1, 8'hA5);
    @(posedge Clock);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge Clock);
      if (i == 0) iValid = 1'b0;
      if (oLCD_Enabled && oLCD_Data == 4'hA) e_hi++;
      if (oLCD_Enabled && oLCD_Data == 4'h5) e_lo++;
      if (oReady && lat == 0) lat = i + 1;
      total++;
      if (obs !== exp_q[i]) begin bad++; $display("FAIL single_a5 cyc=%0d: got=%b want=%b", i+1, obs, exp_q[i]); end
    end
    total++;
    if (e_hi != P || e_lo != P) begin bad++; $display("FAIL a5_pulse_len: hi=%0d lo=%0d want=%0d", e_hi, e_lo, P); end
    total++;
    if (lat != 2*S + 2*P + 2*H + G + B + 1)
      begin bad++; $display("FAIL a5_latency: got=%0d want=%0d", lat, 2*S + 2*P + 2*H + G + B + 1); end
  endtask

  task automatic test_data_change();
    logic [7:0] b;
    bit rs;
    b = 8'($urandom); rs = 1'($urandom);
    wait_ready();
    iValid = 1'b1; iRegisterSelect = rs; iData = b;
    build_expect(rs, b);
    @(posedge Clock);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge Clock);
      total++;
      if (obs !== exp_q[i]) begin bad++; $display("FAIL data_change cyc=%0d: got=%b want=%b", i+1, obs, exp_q[i]); end
      iData = 8'($urandom); iRegisterSelect = 1'($urandom);
      if (i == exp_q.size() - 1) iValid = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b1, b2;
    bit rs1, rs2;
    logic [7:0] e1[$];
    b1 = 8'($urandom); b2 = 8'($urandom); rs1 = 1'($urandom); rs2 = 1'($urandom);
    wait_ready();
    iValid = 1'b1; iRegisterSelect = rs1; iData = b1;
    build_expect(rs1, b1);
    e1 = exp_q;
    @(posedge Clock);
    for (int i = 0; i < e1.size(); i++) begin
      @(negedge Clock);
      total++;
      if (obs !== e1[i]) begin bad++; $display("FAIL b2b_first cyc=%0d: got=%b want=%b", i+1, obs, e1[i]); end
      if (i == 0) begin iRegisterSelect = rs2; iData = b2; end
    end
    build_expect(rs2, b2);
    @(posedge Clock);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge Clock);
      if (i == 0) iValid = 1'b0;
      total++;
      if (obs !== exp_q[i]) begin bad++; $display("FAIL b2b_second cyc=%0d: got=%b want=%b", i+1, obs, exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_byte();
    logic [7:0] b;
    int stop_at, e_seen = 0;
    b = 8'($urandom) | 8'h11;
    stop_at = 2*eff(S) + eff(P) + eff(H) + eff(G) + 2;
    wait_ready();
    iValid = 1'b1; iRegisterSelect = 1'b1; iData = b;
    build_expect(1'b1, b);
    @(posedge Clock);
    for (int i = 0; i < stop_at; i++) begin
      @(negedge Clock);
      if (i == 0) iValid = 1'b0;
      total++;
      if (obs !== exp_q[i]) begin bad++; $display("FAIL pre_reset cyc=%0d: got=%b want=%b", i+1, obs, exp_q[i]); end
    end
    Reset = 1'b1;
    @(negedge Clock);
    total++;
    if (obs !== 8'h00) begin bad++; $display("FAIL mid_reset: got=%b want=%b", obs, 8'h00); end
    Reset = 1'b0;
    #1;
    total++;
    if (obs !== 8'h01) begin bad++; $display("FAIL mid_reset_release: got=%b want=%b", obs, 8'h01); end
    repeat (30) begin
      @(negedge Clock);
      if (oLCD_Enabled || oBusy) e_seen++;
    end
    total++;
    if (e_seen != 0) begin bad++; $display("FAIL no_resume: active cycles=%0d want=0", e_seen); end
  endtask

  task automatic test_clear_gap();
    logic [7:0] bytes[3];
    bit rss[3];
    bytes[0] = 8'h01; rss[0] = 1'b0;
    bytes[1] = 8'h01; rss[1] = 1'b1;
    bytes[2] = 8'h02; rss[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      int lat = 0;
      wait_ready();
      iValid = 1'b1; iRegisterSelect = rss[k]; iData = bytes[k];
      @(posedge Clock);
      @(negedge Clock);
      iValid = 1'b0;
      lat = 1;
      while (!oReady && lat < 200) begin
        @(negedge Clock);
        lat++;
      end
      total++;
      if (lat != latency_of(rss[k], bytes[k]))
        begin bad++; $display("FAIL clear_gap rs=%b byte=%h: latency got=%0d want=%0d", rss[k], bytes[k], lat, latency_of(rss[k], bytes[k])); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      logic [7:0] b;
      bit rs;
      rs = 1'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 2)) : 8'($urandom);
      wait_ready();
      repeat ($urandom_range(0, 3)) @(negedge Clock);
      iValid = 1'b1; iRegisterSelect = rs; iData = b;
      build_expect(rs, b);
      @(posedge Clock);
      for (int i = 0; i < exp_q.size(); i++) begin
        @(negedge Clock);
        if (i == 0) begin iValid = 1'b0; iData = 8'($urandom); end
        total++;
        if (obs !== exp_q[i]) begin bad++; $display("FAIL random n=%0d cyc=%0d: got=%b want=%b", n, i+1, obs, exp_q[i]); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_a5();
    test_data_change();
    test_back_to_back();
    test_reset_mid_byte();
    test_clear_gap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
